// File: rtl/prescaler_ctrl_pkg.sv
// Shared constants for the input_control front end (prescaler + fast-mode button).
package prescaler_ctrl_pkg;

   localparam int unsigned DEF_DIV     = 100;
   localparam int unsigned DEF_CW      = 7;
   localparam int unsigned DEF_DEB_CNT = 3;
   localparam int unsigned DEF_DBW     = 2;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, consecutive-sample debouncer and press edge detector.
module btn_debounce
   import prescaler_ctrl_pkg::*;
#(
   parameter int unsigned DEB_CNT = DEF_DEB_CNT,
   parameter int unsigned DBW     = DEF_DBW
) (
   input  logic clk100,
   input  logic clrn,
   input  logic raw,
   output logic deb,
   output logic press_pulse
);

   logic           sync1;
   logic           btn_s;
   logic           deb_q;
   logic [DBW-1:0] deb_cnt;

   always_ff @(posedge clk100 or negedge clrn) begin
      if (!clrn) begin
         sync1       <= 1'b0;
         btn_s       <= 1'b0;
         deb_cnt     <= '0;
         deb         <= 1'b0;
         deb_q       <= 1'b0;
         press_pulse <= 1'b0;
      end else begin
         sync1 <= raw;
         btn_s <= sync1;
         // Accept a new level only after DEB_CNT consecutive differing samples.
         if (btn_s == deb) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DBW'(DEB_CNT - 1)) begin
            deb     <= btn_s;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + DBW'(1);
         end
         deb_q       <= deb;
         press_pulse <= deb & ~deb_q;
      end
   end

endmodule

// File: rtl/prescaler_ctrl_defs.svh
// Default build constants for prescaler_ctrl, shared with the timer benches.
`ifndef PRESCALER_CTRL_DEFS_SVH
`define PRESCALER_CTRL_DEFS_SVH
`define PRESCALER_CTRL_DIV     100
`define PRESCALER_CTRL_CW      7
`define PRESCALER_CTRL_DEB_CNT 3
`define PRESCALER_CTRL_DBW     2
`endif

// File: rtl/prescaler_ctrl.sv
// 100 Hz -> 1 Hz prescaler plus debounced fast-mode toggle driving the clock select.
module prescaler_ctrl
   import prescaler_ctrl_pkg::*;
#(
   parameter int unsigned DIV     = DEF_DIV,
   parameter int unsigned CW      = DEF_CW,
   parameter int unsigned DEB_CNT = DEF_DEB_CNT,
   parameter int unsigned DBW     = DEF_DBW
) (
   input  logic          clk100,
   input  logic          clrn,
   input  logic          btn_fast,
   input  logic          hold,
   output logic          out_count7NR,
   output logic [CW-1:0] count,
   output logic          enablen,
   output logic          press_pulse
);

   logic [CW-1:0] cnt_nxt;
   logic          deb_unused;

   // Explicit wrap at DIV-1; the counter width is not a power-of-two modulus.
   always_comb begin
      cnt_nxt = count + CW'(1);
      if (count == CW'(DIV - 1)) begin
         cnt_nxt = '0;
      end
   end

   // Square wave is computed from the next count so it stays aligned with count.
   always_ff @(posedge clk100 or negedge clrn) begin
      if (!clrn) begin
         count        <= '0;
         out_count7NR <= 1'b0;
      end else if (!hold) begin
         count        <= cnt_nxt;
         out_count7NR <= (cnt_nxt >= CW'(DIV / 2));
      end
   end

   always_ff @(posedge clk100 or negedge clrn) begin
      if (!clrn) begin
         enablen <= 1'b0;
      end else if (press_pulse) begin
         enablen <= ~enablen;
      end
   end

   btn_debounce #(
      .DEB_CNT (DEB_CNT),
      .DBW     (DBW)
   ) u_btn_debounce (
      .clk100      (clk100),
      .clrn        (clrn),
      .raw         (btn_fast),
      .deb         (deb_unused),
      .press_pulse (press_pulse)
   );

endmodule

// File: tb/tb_prescaler_ctrl.sv
// Directed bench for prescaler_ctrl: vector table plus multi-cycle corner sequences.
module tb_prescaler_ctrl;

   logic       clk100;
   logic       clrn;
   logic       btn_fast;
   logic       hold;
   logic       out_count7NR;
   logic [6:0] count;
   logic       enablen;
   logic       press_pulse;

   int total;
   int bad;

   typedef struct {
      logic hold;
      logic btn;
      int   cnt;
      logic out;
      logic en;
      logic pulse;
   } vec_t;

   vec_t vecs[22];

   prescaler_ctrl dut (
      .clk100       (clk100),
      .clrn         (clrn),
      .btn_fast     (btn_fast),
      .hold         (hold),
      .out_count7NR (out_count7NR),
      .count        (count),
      .enablen      (enablen),
      .press_pulse  (press_pulse)
   );

   initial clk100 = 1'b0;
   always #5 clk100 = ~clk100;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
   task automatic tick();
      @(posedge clk100);
      #1;
   endtask

   task automatic do_reset(input logic btn_level);
      clrn     = 1'b0;
      hold     = 1'b0;
      btn_fast = btn_level;
      tick();
      clrn = 1'b1;
   endtask

   initial begin
      int pulses;
      total    = 0;
      bad      = 0;
      clrn     = 1'b0;
      hold     = 1'b0;
      btn_fast = 1'b0;

      // hold, btn, count, out, enablen, press_pulse after each edge
      vecs[0]  = '{1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1,  2, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b1,  2, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b1,  2, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b1,  3, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b1,  4, 1'b0, 1'b0, 1'b1};
      vecs[6]  = '{1'b0, 1'b1,  5, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b0,  6, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 1'b0,  7, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 1'b0,  8, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 1'b0,  9, 1'b0, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 10, 1'b0, 1'b1, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 11, 1'b0, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 12, 1'b0, 1'b1, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 13, 1'b0, 1'b1, 1'b0};
      vecs[15] = '{1'b0, 1'b1, 14, 1'b0, 1'b1, 1'b0};
      vecs[16] = '{1'b0, 1'b1, 15, 1'b0, 1'b1, 1'b0};
      vecs[17] = '{1'b0, 1'b1, 16, 1'b0, 1'b1, 1'b0};
      vecs[18] = '{1'b0, 1'b1, 17, 1'b0, 1'b1, 1'b0};
      vecs[19] = '{1'b0, 1'b1, 18, 1'b0, 1'b1, 1'b1};
      vecs[20] = '{1'b0, 1'b1, 19, 1'b0, 1'b0, 1'b0};
      vecs[21] = '{1'b0, 1'b1, 20, 1'b0, 1'b0, 1'b0};

      // Reset state
      do_reset(1'b0);
      check("rst_count", int'(count), 0);
      check("rst_out", int'(out_count7NR), 0);
      check("rst_en", int'(enablen), 0);
      check("rst_pulse", int'(press_pulse), 0);

      // Table: press with hold, release (no pulse), second press
      for (int i = 0; i < 22; i++) begin
         hold     = vecs[i].hold;
         btn_fast = vecs[i].btn;
         tick();
         check($sformatf("vec%0d_count", i), int'(count), vecs[i].cnt);
         check($sformatf("vec%0d_out", i), int'(out_count7NR), int'(vecs[i].out));
         check($sformatf("vec%0d_en", i), int'(enablen), int'(vecs[i].en));
         check($sformatf("vec%0d_pulse", i), int'(press_pulse), int'(vecs[i].pulse));
      end

      // Free run 250 cycles
      do_reset(1'b0);
      for (int i = 1; i <= 250; i++) begin
         tick();
         check("run_count", int'(count), i % 100);
         check("run_out", int'(out_count7NR), ((i % 100) >= 50) ? 1 : 0);
         check("run_en", int'(enablen), 0);
      end

      // Hold at 37 for 20 cycles, then resume with 38
      do_reset(1'b0);
      for (int i = 0; i < 37; i++) tick();
      check("pre_hold_count", int'(count), 37);
      hold = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("hold_count", int'(count), 37);
         check("hold_out", int'(out_count7NR), 0);
      end
      hold = 1'b0;
      tick();
      check("hold_resume", int'(count), 38);

      // Bounce 1,0,1,0 then steady 1: exactly one pulse
      do_reset(1'b0);
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         btn_fast = (i < 4) ? ((i % 2) == 0) : 1'b1;
         tick();
         if (press_pulse) pulses++;
      end
      check("bounce_pulses", pulses, 1);
      check("bounce_en", int'(enablen), 1);

      // Isolated 2-cycle glitch: no pulse
      do_reset(1'b0);
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         btn_fast = (i < 2);
         tick();
         if (press_pulse) pulses++;
      end
      check("glitch_pulses", pulses, 0);
      check("glitch_en", int'(enablen), 0);

      // Asynchronous reset at count=73 while a debounce is in progress
      do_reset(1'b0);
      for (int i = 0; i < 70; i++) tick();
      btn_fast = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      check("pre_clr_count", int'(count), 73);
      clrn = 1'b0;
      #1;
      check("clr_count", int'(count), 0);
      check("clr_out", int'(out_count7NR), 0);
      check("clr_en", int'(enablen), 0);
      check("clr_pulse", int'(press_pulse), 0);
      btn_fast = 1'b0;
      #1;
      clrn = 1'b1;
      pulses = 0;
      for (int i = 1; i <= 15; i++) begin
         tick();
         check("post_clr_count", int'(count), i);
         if (press_pulse) pulses++;
      end
      check("post_clr_pulses", pulses, 0);
      check("post_clr_en", int'(enablen), 0);

      // Button held through reset release is a fresh press
      do_reset(1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("held_rst_nopulse", int'(press_pulse), 0);
      end
      tick();
      check("held_rst_pulse", int'(press_pulse), 1);
      tick();
      check("held_rst_en", int'(enablen), 1);
      check("held_rst_pulse_end", int'(press_pulse), 0);

      // Press at count=99 while held, then release hold to wrap
      do_reset(1'b0);
      for (int i = 0; i < 99; i++) tick();
      check("c99_count", int'(count), 99);
      check("c99_out", int'(out_count7NR), 1);
      hold     = 1'b1;
      btn_fast = 1'b1;
      pulses   = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("c99_hold_count", int'(count), 99);
         check("c99_hold_out", int'(out_count7NR), 1);
         if (press_pulse) pulses++;
      end
      check("c99_pulses", pulses, 1);
      check("c99_en", int'(enablen), 1);
      hold = 1'b0;
      tick();
      check("c99_wrap_count", int'(count), 0);
      check("c99_wrap_out", int'(out_count7NR), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
